ccu_loop_seq: RTL and testbench

Layer/frame/patch loop sequencer for the CMP phase of the top-level control unit. Once configuration is read and the top start pulse arrives, it walks the nested loop of layers, frames per layer and patches per frame. It issues one start pulse per patch to the activation/weight controllers and waits for each patch-done. It emits the layer-boundary and network-finish events that the top FSM uses to leave CMP.

---
 rtl/ccu_pkg.sv | 17 +
 rtl/ccu_loop_cnt.sv | 27 ++
 rtl/ccu_loop_seq.sv | 115 +++++++++++
 tb/tb_ccu_loop_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ccu_pkg.sv
// Shared state encoding and default loop widths for the CMP loop sequencer.
// Pure declarations: no latency, no flow control.
package ccu_pkg;

  localparam int LAYER_W = 5;
  localparam int FRM_W   = 6;
  localparam int PAT_W   = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAITGBF = 3'd1,
    ISSUE   = 3'd2,
    RUN     = 3'd3,
    DONE    = 3'd4
  } ccu_state_e;

endpackage

// File: rtl/ccu_loop_cnt.sv
// Loop index counter with terminal flag; updates on the edge after inc/clr, last is combinational.
// No backpressure: clr wins over inc, and inc at the terminal value wraps to zero.
module ccu_loop_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         last
);

  assign last = (cnt == max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ccu_loop_seq.sv
// Layer/frame/patch loop sequencer for CMP; one pat_start per patch, next patch one cycle after pat_done.
// Stalls in WAITGBF until gbf_val and in RUN until pat_done; abort returns to IDLE on the next edge.
module ccu_loop_seq
  import ccu_pkg::*;
#(
  parameter int LAYER_W = ccu_pkg::LAYER_W,
  parameter int FRM_W   = ccu_pkg::FRM_W,
  parameter int PAT_W   = ccu_pkg::PAT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [LAYER_W-1:0] cfg_num_layer,
  input  logic [FRM_W-1:0]   cfg_num_frm,
  input  logic [PAT_W-1:0]   cfg_num_pat,
  input  logic               top_sta,
  input  logic               gbf_val,
  input  logic               pat_done,
  input  logic               abort,
  output logic               pat_start,
  output logic               fnh_frm,
  output logic               rst_layer,
  output logic               fnh_net,
  output logic               busy,
  output logic [LAYER_W-1:0] layer_idx,
  output logic [FRM_W-1:0]   frm_idx,
  output logic [PAT_W-1:0]   pat_idx
);

  ccu_state_e         state_q, state_d;
  logic [LAYER_W-1:0] cfg_layer_q;
  logic [FRM_W-1:0]   cfg_frm_q;
  logic [PAT_W-1:0]   cfg_pat_q;
  logic               pat_last, frm_last, layer_last;
  logic               cnt_clr, pat_inc, frm_inc, layer_inc;
  logic               fnh_frm_d, rst_layer_d;
  logic               fnh_frm_q, rst_layer_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fnh_frm_q   <= 1'b0;
      rst_layer_q <= 1'b0;
      cfg_layer_q <= '0;
      cfg_frm_q   <= '0;
      cfg_pat_q   <= '0;
    end else begin
      state_q     <= state_d;
      fnh_frm_q   <= fnh_frm_d;
      rst_layer_q <= rst_layer_d;
      if (state_q == IDLE && cfg_load) begin
        cfg_layer_q <= cfg_num_layer;
        cfg_frm_q   <= cfg_num_frm;
        cfg_pat_q   <= cfg_num_pat;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    fnh_frm_d = 1'b0;
    case (state_q)
      IDLE:    if (top_sta) state_d = WAITGBF;
      WAITGBF: if (gbf_val) state_d = ISSUE;
      ISSUE:   state_d = RUN;
      RUN: begin
        if (pat_done) begin
          if (!pat_last) begin
            state_d = ISSUE;
          end else begin
            fnh_frm_d = 1'b1;
            if (!frm_last)        state_d = ISSUE;
            else if (!layer_last) state_d = WAITGBF;
            else                  state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      fnh_frm_d = 1'b0;
    end
    rst_layer_d = (state_d == WAITGBF) && (state_q != WAITGBF);
  end

  // Indices hold on the final patch so they still name it while DONE is presented.
  assign cnt_clr   = abort || (state_q == IDLE);
  assign pat_inc   = (state_q == RUN) && pat_done && !(pat_last && frm_last && layer_last);
  assign frm_inc   = pat_inc && pat_last;
  assign layer_inc = frm_inc && frm_last;

  ccu_loop_cnt #(.W(PAT_W)) u_pat_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(pat_inc),
    .max(cfg_pat_q), .cnt(pat_idx), .last(pat_last)
  );

  ccu_loop_cnt #(.W(FRM_W)) u_frm_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(frm_inc),
    .max(cfg_frm_q), .cnt(frm_idx), .last(frm_last)
  );

  ccu_loop_cnt #(.W(LAYER_W)) u_layer_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(layer_inc),
    .max(cfg_layer_q), .cnt(layer_idx), .last(layer_last)
  );

  assign pat_start = (state_q == ISSUE);
  assign fnh_net   = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign fnh_frm   = fnh_frm_q;
  assign rst_layer = rst_layer_q;

endmodule

// File: tb/tb_ccu_loop_seq.sv
// Bench for ccu_loop_seq: reactive datapath/buffer responder checked against a nested-loop patch list.
// Directed runs, abort, async reset and randomized configs with spurious inputs.
module tb_ccu_loop_seq;

  localparam int LW = 5;
  localparam int FW = 6;
  localparam int PW = 8;

  typedef logic [LW+FW+PW-1:0] pos_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_load = 1'b0;
  logic [LW-1:0] cfg_num_layer = '0;
  logic [FW-1:0] cfg_num_frm = '0;
  logic [PW-1:0] cfg_num_pat = '0;
  logic          top_sta = 1'b0;
  logic          gbf_val = 1'b0;
  logic          pat_done = 1'b0;
  logic          abort = 1'b0;
  logic          pat_start, fnh_frm, rst_layer, fnh_net, busy;
  logic [LW-1:0] layer_idx;
  logic [FW-1:0] frm_idx;
  logic [PW-1:0] pat_idx;

  int   n_chk = 0;
  int   n_fail = 0;
  pos_t ref_q[$];
  pos_t obs_q[$];

  always #5 clk = ~clk;

  ccu_loop_seq dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load),
    .cfg_num_layer(cfg_num_layer), .cfg_num_frm(cfg_num_frm), .cfg_num_pat(cfg_num_pat),
    .top_sta(top_sta), .gbf_val(gbf_val), .pat_done(pat_done), .abort(abort),
    .pat_start(pat_start), .fnh_frm(fnh_frm), .rst_layer(rst_layer), .fnh_net(fnh_net),
    .busy(busy), .layer_idx(layer_idx), .frm_idx(frm_idx), .pat_idx(pat_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pulses"}, {pat_start, fnh_frm, rst_layer, fnh_net}, 0);
    check({tag, "_idx"}, {layer_idx, frm_idx, pat_idx}, 0);
  endtask

  task automatic load_cfg(input int nl, input int nf, input int np);
    cfg_num_layer = LW'(nl);
    cfg_num_frm   = FW'(nf);
    cfg_num_pat   = PW'(np);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  // Drives one network run and compares it with the patch list the loop bounds imply.
  task automatic do_run(input int nl, input int nf, input int np, input bit load,
                        input int gbf_dly, input int pd_max, input bit spur);
    int   total, per_layer, n_done, pd_wait, gbf_wait, budget, c_frm, c_lay, c_net;
    bit   armed, prev_pd, gbf_rose, spur_iss, spur_wg, finished;
    pos_t hold;
    ref_q.delete();
    obs_q.delete();
    for (int l = 0; l <= nl; l++)
      for (int f = 0; f <= nf; f++)
        for (int p = 0; p <= np; p++)
          ref_q.push_back({LW'(l), FW'(f), PW'(p)});
    total = (nl + 1) * (nf + 1) * (np + 1);
    per_layer = (nf + 1) * (np + 1);
    n_done = 0; pd_wait = 0; gbf_wait = -1; budget = 3000;
    c_frm = 0; c_lay = 0; c_net = 0;
    armed = 0; prev_pd = 0; gbf_rose = 0; spur_iss = 0; spur_wg = 0; finished = 0;
    hold = '0;
    abort = 1'b0;
    if (load) load_cfg(nl, nf, np);
    top_sta = 1'b1;
    tick();
    top_sta = 1'b0;
    check("start_busy", busy, 1);
    while (!finished && budget > 0) begin
      pat_done = 1'b0; top_sta = 1'b0; cfg_load = 1'b0;
      if (fnh_frm)   c_frm++;
      if (rst_layer) c_lay++;
      if (fnh_net)   c_net++;
      if (pat_start) obs_q.push_back({layer_idx, frm_idx, pat_idx});
      if (spur_iss || spur_wg) begin
        check("spurious_no_start", pat_start, 0);
        check("spurious_busy", busy, 1);
        check("spurious_idx_hold", {layer_idx, frm_idx, pat_idx}, hold);
      end
      if (spur_wg) check("rst_layer_one_cycle", rst_layer, 0);
      if (gbf_wait >= 0 && !rst_layer) check("no_start_while_gbf_low", pat_start, 0);
      if (gbf_rose) check("gbf_to_start", pat_start, 1);
      if (prev_pd) begin
        check("fnh_frm_at_frame_end", fnh_frm, (n_done % (np + 1)) == 0);
        if (n_done == total) begin
          check("fnh_net_after_last", fnh_net, 1);
          tick();
          check("busy_low_after_done", busy, 0);
          check("fnh_net_one_cycle", fnh_net, 0);
          finished = 1;
        end else if (n_done % per_layer == 0) begin
          check("rst_layer_at_layer_end", rst_layer, 1);
        end else begin
          check("pat_done_to_start", pat_start, 1);
        end
      end
      if (!finished) begin
        prev_pd = 0; gbf_rose = 0; spur_iss = 0; spur_wg = 0;
        hold = {layer_idx, frm_idx, pat_idx};
        if (rst_layer) begin
          gbf_val = 1'b0;
          gbf_wait = gbf_dly;
          if (spur && gbf_dly > 0) begin
            pat_done = 1'b1;
            spur_wg = 1;
          end
        end
        if (gbf_wait == 0) begin
          gbf_val = 1'b1;
          gbf_wait = -1;
          gbf_rose = 1;
        end else if (gbf_wait > 0) begin
          gbf_wait--;
        end
        if (pat_start) begin
          armed = 1;
          pd_wait = $urandom_range(0, pd_max);
          if (spur) begin
            pat_done = 1'b1;
            spur_iss = 1;
          end
        end else if (armed) begin
          if (pd_wait == 0) begin
            pat_done = 1'b1;
            armed = 0;
            prev_pd = 1;
            n_done++;
          end else begin
            pd_wait--;
          end
          if (spur) begin
            top_sta = 1'b1;
            cfg_load = 1'b1;
            cfg_num_layer = LW'($urandom);
            cfg_num_frm = FW'($urandom);
            cfg_num_pat = PW'($urandom);
          end
        end
        tick();
        budget--;
      end
    end
    pat_done = 1'b0; top_sta = 1'b0; cfg_load = 1'b0;
    check("run_completed", finished, 1);
    check("pat_start_count", obs_q.size(), total);
    check("fnh_frm_count", c_frm, (nl + 1) * (nf + 1));
    check("rst_layer_count", c_lay, nl + 1);
    check("fnh_net_count", c_net, 1);
    for (int i = 0; i < ref_q.size(); i++)
      if (i < obs_q.size()) check("patch_order", obs_q[i], ref_q[i]);
  endtask

  // Runs with immediate responses until patch pidx of the first frame is issued, then steps into RUN.
  task automatic run_to_patch(input int pidx);
    bit hit, issue_prev;
    int budget;
    hit = 0; issue_prev = 0; budget = 200;
    gbf_val = 1'b1;
    top_sta = 1'b1;
    tick();
    top_sta = 1'b0;
    while (!hit && budget > 0) begin
      pat_done = issue_prev;
      issue_prev = pat_start;
      if (pat_start && pat_idx == PW'(pidx)) hit = 1;
      tick();
      budget--;
    end
    pat_done = 1'b0;
    check("target_patch_reached", hit, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_idle("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    // single patch network
    gbf_val = 1'b1;
    do_run(0, 0, 0, 1, 0, 0, 0);
    // two layers, two frames, three patches, immediate responses
    do_run(1, 1, 2, 1, 0, 0, 0);
    check("last_start_idx", obs_q.size() > 0 ? obs_q[obs_q.size() - 1] : '1, {LW'(1), FW'(1), PW'(2)});
    // buffer held off for 10 cycles per layer
    do_run(1, 0, 1, 1, 10, 1, 0);
    // spurious pat_done/top_sta/cfg_load while running
    do_run(1, 1, 2, 1, 2, 2, 1);

    // abort in RUN at pat_idx 3, then restart on retained config
    load_cfg(1, 1, 5);
    run_to_patch(3);
    abort = 1'b1;
    pat_done = 1'b1;
    tick();
    abort = 1'b0;
    pat_done = 1'b0;
    check_idle("abort");
    tick();
    check("abort_stays_idle", busy, 0);
    do_run(1, 1, 5, 0, 1, 2, 0);

    // async reset mid-patch, config returns to zero
    load_cfg(0, 2, 3);
    run_to_patch(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_idle("after_async_reset");
    do_run(0, 0, 0, 0, 0, 1, 0);

    for (int r = 0; r < 4; r++)
      do_run($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 4), 1,
             $urandom_range(0, 3), 3, (r % 2) == 1);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
